transient_generator: RTL and testbench

- Stimulus-side counterpart of the state monitor: drives a single-bit monitored signal, emitting a programmable train of "invalid-level" pulses separated by "valid-level" gaps.
- Sits on the same tile as the monitor. Used for on-silicon self-test: o_signal loops back to the monitor's signal input to exercise its transient/hold-off path.
- Timing uses the same unit scheme as the monitor: a 4-bit setting n gives (n+1)*UNIT_CYCLES clocks.

---
 rtl/transient_generator.sv | 182 ++++++++++++++++++
 tb/tb_transient_generator.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/transient_generator.sv
// -----------------------------------------------------------------------------
// transient_generator
//   Stimulus-side self-test source for the state monitor. Drives a single-bit
//   signal with a programmable train of invalid-level pulses separated by
//   valid-level gaps. A 4-bit timing setting n gives (n+1)*UNIT_CYCLES clocks.
//
//   Optional feature: define TRANSIENT_GEN_BOUNCE_EN to make the first four
//   cycles of every pulse emulate contact bounce (invalid, valid, invalid,
//   valid) before holding invalid for the rest of the pulse. Total pulse
//   length is unchanged; requires UNIT_CYCLES >= 5.
//
// Ports:
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset
//   i_start      start request, honoured in IDLE only
//   i_stop       abort request, honoured in every state (wins over start)
//   i_polarity   valid level of o_signal (pulses drive the opposite level)
//   i_width      pulse length setting, L = (i_width+1)*UNIT_CYCLES
//   i_gap        gap length setting,   G = (i_gap+1)*UNIT_CYCLES
//   i_count      pulses per train, 0 = continuous until stop
//   o_signal     generated signal (registered)
//   o_busy       high while a train is running (registered)
//   o_done       one-cycle strobe when a finite train completes
//   o_pulse_cnt  completed pulses in current/last train (wraps)
// -----------------------------------------------------------------------------
module transient_generator #(
    parameter int UNIT_CYCLES = 10000,
    parameter int TIMER_W     = 18,
    parameter int COUNT_W     = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_polarity,
    input  logic [3:0]         i_width,
    input  logic [3:0]         i_gap,
    input  logic [COUNT_W-1:0] i_count,
    output logic               o_signal,
    output logic               o_busy,
    output logic               o_done,
    output logic [COUNT_W-1:0] o_pulse_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PULSE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [TIMER_W-1:0] UNIT_W = TIMER_W'(UNIT_CYCLES);
    localparam logic [TIMER_W-1:0] ONE_W  = {{(TIMER_W-1){1'b0}}, 1'b1};
    localparam logic [COUNT_W-1:0] ONE_C  = {{(COUNT_W-1){1'b0}}, 1'b1};

    // Phase length in clocks for a 4-bit setting, computed at full timer width.
    function automatic logic [TIMER_W-1:0] phase_len_f(input logic [3:0] n);
        phase_len_f = (TIMER_W'(n) + ONE_W) * UNIT_W;
    endfunction

    logic [1:0]         state_r,  state_s;
    logic [TIMER_W-1:0] timer_r,  timer_s;
    logic               sig_r,    sig_s;
    logic               busy_r;
    logic               done_r,   done_s;
    logic [COUNT_W-1:0] cnt_r,    cnt_s;
    logic               pol_r,    pol_s;
    logic [3:0]         width_r,  width_s;
    logic [3:0]         gap_r,    gap_s;
    logic [COUNT_W-1:0] count_r,  count_s;

    logic [COUNT_W-1:0] cnt_inc_s;
    logic               pulse_level_s;

    assign cnt_inc_s = cnt_r + ONE_C;

`ifdef TRANSIENT_GEN_BOUNCE_EN
    // Index of the next pulse cycle (0-based); timer starts at L-1 on entry.
    logic [TIMER_W-1:0] next_idx_s;
    assign next_idx_s    = phase_len_f(width_r) - timer_r;
    assign pulse_level_s = ((next_idx_s == TIMER_W'(1)) || (next_idx_s == TIMER_W'(3)))
                           ? pol_r : ~pol_r;
`else
    assign pulse_level_s = ~pol_r;
`endif

    // Next-state, timer, output and config-latch logic.
    always_comb begin
        state_s = state_r;
        timer_s = timer_r;
        sig_s   = sig_r;
        done_s  = 1'b0;
        cnt_s   = cnt_r;
        pol_s   = pol_r;
        width_s = width_r;
        gap_s   = gap_r;
        count_s = count_r;
        if (i_stop) begin
            // Abort: back to idle at the latched valid level, count held.
            state_s = ST_IDLE;
            sig_s   = pol_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    sig_s = i_polarity;
                    if (i_start) begin
                        pol_s   = i_polarity;
                        width_s = i_width;
                        gap_s   = i_gap;
                        count_s = i_count;
                        cnt_s   = '0;
                        sig_s   = ~i_polarity;
                        timer_s = phase_len_f(i_width) - ONE_W;
                        state_s = ST_PULSE;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_PULSE: begin
                    if (timer_r == '0) begin
                        cnt_s = cnt_inc_s;
                        sig_s = pol_r;
                        // Finite train ends on its last pulse; no trailing gap.
                        if ((count_r != '0) && (cnt_inc_s == count_r)) begin
                            done_s  = 1'b1;
                            state_s = ST_IDLE;
                        end else begin
                            timer_s = phase_len_f(gap_r) - ONE_W;
                            state_s = ST_GAP;
                        end
                    end else begin
                        timer_s = timer_r - ONE_W;
                        sig_s   = pulse_level_s;
                    end
                end
                ST_GAP: begin
                    if (timer_r == '0) begin
                        sig_s   = ~pol_r;
                        timer_s = phase_len_f(width_r) - ONE_W;
                        state_s = ST_PULSE;
                    end else begin
                        timer_s = timer_r - ONE_W;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    sig_s   = pol_r;
                end
            endcase
        end
    end

    // State, timer, outputs and latched configuration registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
            timer_r <= '0;
            sig_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            cnt_r   <= '0;
            pol_r   <= 1'b0;
            width_r <= 4'd0;
            gap_r   <= 4'd0;
            count_r <= '0;
        end else begin
            state_r <= state_s;
            timer_r <= timer_s;
            sig_r   <= sig_s;
            busy_r  <= (state_s != ST_IDLE);
            done_r  <= done_s;
            cnt_r   <= cnt_s;
            pol_r   <= pol_s;
            width_r <= width_s;
            gap_r   <= gap_s;
            count_r <= count_s;
        end
    end

    assign o_signal    = sig_r;
    assign o_busy      = busy_r;
    assign o_done      = done_r;
    assign o_pulse_cnt = cnt_r;

endmodule

// File: tb/tb_transient_generator.sv
// -----------------------------------------------------------------------------
// tb_transient_generator
//   Directed scenarios plus randomized stimulus for transient_generator, checked
//   every cycle against a phase/elapsed-time reference model.
//   Simulation parameters: UNIT_CYCLES=4, COUNT_W=2 (quick counter wrap).
// -----------------------------------------------------------------------------
module tb_transient_generator;

    localparam int UNIT = 4;
    localparam int CW   = 2;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_start;
    logic          i_stop;
    logic          i_polarity;
    logic [3:0]    i_width;
    logic [3:0]    i_gap;
    logic [CW-1:0] i_count;
    logic          o_signal;
    logic          o_busy;
    logic          o_done;
    logic [CW-1:0] o_pulse_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: phase (0 idle, 1 pulse, 2 gap) and cycles elapsed in it.
    int m_mode, m_el;
    int m_sig, m_busy, m_done, m_cnt;
    int m_pol, m_w, m_g, m_c;

    transient_generator #(
        .UNIT_CYCLES(UNIT),
        .TIMER_W    (18),
        .COUNT_W    (CW)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .i_stop     (i_stop),
        .i_polarity (i_polarity),
        .i_width    (i_width),
        .i_gap      (i_gap),
        .i_count    (i_count),
        .o_signal   (o_signal),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_pulse_cnt(o_pulse_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_mode = 0; m_el = 0; m_sig = 0; m_busy = 0; m_done = 0; m_cnt = 0;
        m_pol = 0; m_w = 0; m_g = 0; m_c = 0;
    endtask

    // One clock edge of the specified behaviour, using the inputs seen at the edge.
    task automatic model_step();
        int plen, glen;
        plen   = (m_w + 1) * UNIT;
        glen   = (m_g + 1) * UNIT;
        m_done = 0;
        if (i_stop) begin
            m_mode = 0;
            m_sig  = m_pol;
        end else if (m_mode == 0) begin
            m_sig = i_polarity;
            if (i_start) begin
                m_pol = i_polarity; m_w = i_width; m_g = i_gap; m_c = i_count;
                m_cnt = 0; m_mode = 1; m_el = 0; m_sig = 1 - m_pol;
            end
        end else if (m_mode == 1) begin
            m_el++;
            if (m_el == plen) begin
                m_cnt = (m_cnt + 1) % (1 << CW);
                m_sig = m_pol;
                if (m_c != 0 && m_cnt == m_c) begin
                    m_mode = 0; m_done = 1;
                end else begin
                    m_mode = 2; m_el = 0;
                end
            end else begin
`ifdef TRANSIENT_GEN_BOUNCE_EN
                m_sig = (m_el == 1 || m_el == 3) ? m_pol : 1 - m_pol;
`else
                m_sig = 1 - m_pol;
`endif
            end
        end else begin
            m_el++;
            if (m_el == glen) begin
                m_mode = 1; m_el = 0; m_sig = 1 - m_pol;
            end
        end
        m_busy = (m_mode != 0) ? 1 : 0;
    endtask

    task automatic compare_all();
        check_val("signal",    int'(o_signal),    m_sig);
        check_val("busy",      int'(o_busy),      m_busy);
        check_val("done",      int'(o_done),      m_done);
        check_val("pulse_cnt", int'(o_pulse_cnt), m_cnt);
    endtask

    // Advance one clock, step the model, compare just after the edge.
    task automatic cycle();
        @(posedge i_clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic set_cfg(input int pol, input int w, input int g, input int c);
        i_polarity = pol[0];
        i_width    = w[3:0];
        i_gap      = g[3:0];
        i_count    = c[CW-1:0];
    endtask

    initial begin : main
        int busy_cycles, done_cycles, hi_cycles;
        int cnt_seq[$];
        int last_cnt;
        int exp_seq[5];

        i_rst_n = 1'b0; i_start = 1'b0; i_stop = 1'b0;
        set_cfg(1, 0, 0, 0);
        model_reset();
        #12;
        compare_all();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        cycle();

        // Reset mid-pulse: outputs clear without a clock edge.
        set_cfg(1, 2, 1, 0);
        i_start = 1'b1; cycle(); i_start = 1'b0;
        repeat (3) cycle();
        i_rst_n = 1'b0;
        #1;
        model_reset();
        check_val("rst_signal", int'(o_signal), 0);
        check_val("rst_busy",   int'(o_busy),   0);
        compare_all();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        cycle();
        check_val("rst_follow_pol", int'(o_signal), 1);

        // Basic train: pol=1, width=1, gap=0, count=2 -> busy 20 cycles, 1 done.
        set_cfg(1, 1, 0, 2);
        i_start = 1'b1; cycle(); i_start = 1'b0;
        busy_cycles = int'(o_busy); done_cycles = 0;
        repeat (24) begin
            cycle();
            busy_cycles += int'(o_busy);
            done_cycles += int'(o_done);
        end
        check_val("basic_busy_len", busy_cycles, 20);
        check_val("basic_done_cnt", done_cycles, 1);
        check_val("basic_pulse_cnt", int'(o_pulse_cnt), 2);

        // Polarity 0, width 0, count 1: high for exactly 4 cycles, then done.
        set_cfg(0, 0, 0, 1);
        cycle();
        i_start = 1'b1; cycle(); i_start = 1'b0;
        hi_cycles = int'(o_signal); done_cycles = 0;
        repeat (8) begin
            cycle();
            hi_cycles   += int'(o_signal);
            done_cycles += int'(o_done);
        end
        check_val("pol0_high_len", hi_cycles, 4);
        check_val("pol0_done_cnt", done_cycles, 1);

        // Stop abort in second pulse; changed width/start mid-train ignored.
        set_cfg(1, 3, 3, 0);
        cycle();
        i_start = 1'b1; cycle(); i_start = 1'b0;
        i_width = 4'd15;
        repeat (10) cycle();
        i_start = 1'b1; cycle(); i_start = 1'b0;
        repeat (23) cycle();
        i_stop = 1'b1; cycle(); i_stop = 1'b0;
        check_val("stop_busy",   int'(o_busy),      0);
        check_val("stop_signal", int'(o_signal),    1);
        check_val("stop_cnt",    int'(o_pulse_cnt), 1);

        // Start and stop together in idle: stop wins.
        i_start = 1'b1; i_stop = 1'b1; cycle();
        i_start = 1'b0; i_stop = 1'b0;
        check_val("startstop_idle", int'(o_busy), 0);
        cycle();

        // Continuous wrap: counts 1,2,3,0,1 with no done.
        set_cfg(1, 0, 0, 0);
        i_start = 1'b1; cycle(); i_start = 1'b0;
        last_cnt = int'(o_pulse_cnt); done_cycles = 0;
        repeat (40) begin
            cycle();
            done_cycles += int'(o_done);
            if (int'(o_pulse_cnt) != last_cnt) cnt_seq.push_back(int'(o_pulse_cnt));
            last_cnt = int'(o_pulse_cnt);
        end
        exp_seq = '{1, 2, 3, 0, 1};
        check_val("wrap_len", cnt_seq.size(), 5);
        for (int k = 0; k < 5 && k < cnt_seq.size(); k++)
            check_val("wrap_seq", cnt_seq[k], exp_seq[k]);
        check_val("wrap_done", done_cycles, 0);
        i_stop = 1'b1; cycle(); i_stop = 1'b0;

        // Randomized stimulus, checked every cycle by the model.
        for (int n = 0; n < 3000; n++) begin
            i_start = ($urandom_range(0, 5) == 0);
            i_stop  = ($urandom_range(0, 60) == 0);
            set_cfg($urandom_range(0, 1), $urandom_range(0, 4),
                    $urandom_range(0, 4), $urandom_range(0, 3));
            if (i_stop && m_mode == 0) i_polarity = m_pol[0];
            cycle();
        end
        i_start = 1'b0; i_stop = 1'b0;
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
